// File: rtl/codon_pkg.sv
// Shared definitions for the codon reader and its read-out sequencer.
// The package holds the sequencer state type, the array geometry, and
// the nibble value that marks an empty codon slot.
package codon_pkg;

  localparam int NUM_CODONS = 5;
  localparam int MAX_LEN    = 6;

  localparam logic [3:0] EMPTY_NIBBLE = 4'hF;
  localparam logic [2:0] LAST_INDEX   = 3'(MAX_LEN - 1);
  // codon_id reaches this value once every slot has been considered
  localparam logic [2:0] ID_END       = 3'(NUM_CODONS);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_READER = 3'd1,
    ST_SELECT      = 3'd2,
    ST_STREAM      = 3'd3,
    ST_DONE        = 3'd4
  } seq_state_e;

endpackage

// File: rtl/codon_select_mux.sv
// Combinational selection of one codon's current nibble and its
// end-of-codon flag by codon number.
// Ports:
//   codon_id       in   0-based codon number
//   codon1..codon5 in   reader nibbles at the current index
//   end_of_codon   in   per-codon "next nibble is empty" flags
//   nibble         out  nibble of the selected codon
//   end_flag       out  end-of-codon flag of the selected codon
// An out-of-range codon_id selects an empty slot that reads as ended.
module codon_select_mux
  import codon_pkg::*;
(
  input  logic [2:0]            codon_id,
  input  logic [3:0]            codon1,
  input  logic [3:0]            codon2,
  input  logic [3:0]            codon3,
  input  logic [3:0]            codon4,
  input  logic [3:0]            codon5,
  input  logic [NUM_CODONS-1:0] end_of_codon,
  output logic [3:0]            nibble,
  output logic                  end_flag
);

  always_comb begin
    nibble   = EMPTY_NIBBLE;
    end_flag = 1'b1;
    case (codon_id)
      3'd0: begin nibble = codon1; end_flag = end_of_codon[0]; end
      3'd1: begin nibble = codon2; end_flag = end_of_codon[1]; end
      3'd2: begin nibble = codon3; end_flag = end_of_codon[2]; end
      3'd3: begin nibble = codon4; end_flag = end_of_codon[3]; end
      3'd4: begin nibble = codon5; end_flag = end_of_codon[4]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/codon_sequencer.sv
// Read-out sequencer for the codon reader. After the reader reports its
// load is complete, each enabled, non-empty codon is streamed nibble by
// nibble over a valid/ready handshake, then done is raised.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | after reset, waiting for start
// ST_WAIT_READER | run accepted, waiting for done_reader
// ST_SELECT    | scanning codon_id for the next enabled, non-empty codon
// ST_STREAM    | presenting nibbles of codon_id to the consumer
// ST_DONE      | run complete, codons_played held until next start
//
// Ports:
//   clock, reset_n            clock and async active-low reset
//   start, codon_mask         run request and per-codon enable mask
//   done_reader               reader load-complete flag
//   codon1..codon5            reader nibbles at codon_index
//   end_of_codon              reader "next nibble is empty" flags
//   codon_index               nibble index driven to the reader
//   nibble_out, nibble_valid,
//   nibble_ready, last_nibble streaming handshake to the consumer
//   codon_id                  codon currently selected
//   busy, done                run status
//   codons_played             codons fully streamed this run
module codon_sequencer
  import codon_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [NUM_CODONS-1:0] codon_mask,
  input  logic                  done_reader,
  input  logic [3:0]            codon1,
  input  logic [3:0]            codon2,
  input  logic [3:0]            codon3,
  input  logic [3:0]            codon4,
  input  logic [3:0]            codon5,
  input  logic [NUM_CODONS-1:0] end_of_codon,
  output logic [2:0]            codon_index,
  output logic [3:0]            nibble_out,
  output logic                  nibble_valid,
  input  logic                  nibble_ready,
  output logic [2:0]            codon_id,
  output logic                  last_nibble,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            codons_played
);

  seq_state_e            state_q, state_d;
  logic [2:0]            codon_index_q, codon_index_d;
  logic [2:0]            codon_id_q, codon_id_d;
  logic [2:0]            codons_played_q, codons_played_d;
  logic [NUM_CODONS-1:0] mask_q, mask_d;

  logic [3:0] sel_nibble;
  logic       sel_end;
  logic       sel_enabled;
  logic       at_last;

  codon_select_mux u_mux (
    .codon_id     (codon_id_q),
    .codon1       (codon1),
    .codon2       (codon2),
    .codon3       (codon3),
    .codon4       (codon4),
    .codon5       (codon5),
    .end_of_codon (end_of_codon),
    .nibble       (sel_nibble),
    .end_flag     (sel_end)
  );

  assign sel_enabled = (codon_id_q < ID_END) && mask_q[codon_id_q];
  // The final index slot ends a codon even without a trailing empty nibble.
  assign at_last     = sel_end || (codon_index_q == LAST_INDEX);

  always_comb begin
    state_d         = state_q;
    codon_index_d   = codon_index_q;
    codon_id_d      = codon_id_q;
    codons_played_d = codons_played_q;
    mask_d          = mask_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_d          = codon_mask;
          codon_id_d      = 3'd0;
          codon_index_d   = 3'd0;
          codons_played_d = 3'd0;
          state_d         = ST_WAIT_READER;
        end
      end
      ST_WAIT_READER: begin
        codon_index_d = 3'd0;
        if (done_reader) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // codon_index is 0 here, so sel_nibble is the codon's first nibble
        if (codon_id_q == ID_END) begin
          codon_index_d = 3'd0;
          state_d       = ST_DONE;
        end else if (sel_enabled && (sel_nibble != EMPTY_NIBBLE)) begin
          state_d = ST_STREAM;
        end else begin
          codon_id_d = codon_id_q + 3'd1;
        end
      end
      ST_STREAM: begin
        if (nibble_ready) begin
          if (at_last) begin
            codon_index_d   = 3'd0;
            codon_id_d      = codon_id_q + 3'd1;
            codons_played_d = codons_played_q + 3'd1;
            state_d         = ST_SELECT;
          end else begin
            codon_index_d = codon_index_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      codon_index_q   <= 3'd0;
      codon_id_q      <= 3'd0;
      codons_played_q <= 3'd0;
      mask_q          <= '0;
    end else begin
      state_q         <= state_d;
      codon_index_q   <= codon_index_d;
      codon_id_q      <= codon_id_d;
      codons_played_q <= codons_played_d;
      mask_q          <= mask_d;
    end
  end

  assign nibble_valid  = (state_q == ST_STREAM);
  assign nibble_out    = nibble_valid ? sel_nibble : 4'h0;
  assign last_nibble   = nibble_valid && at_last;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign codon_index   = codon_index_q;
  assign codon_id      = codon_id_q;
  assign codons_played = codons_played_q;

endmodule

// File: tb/tb_codon_sequencer.sv
module tb_codon_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] codon_mask = 5'd0;
  logic       done_reader = 1'b1;
  logic [3:0] codon1, codon2, codon3, codon4, codon5;
  logic [4:0] end_of_codon;
  logic [2:0] codon_index;
  logic [3:0] nibble_out;
  logic       nibble_valid;
  logic       nibble_ready = 1'b1;
  logic [2:0] codon_id;
  logic       last_nibble;
  logic       busy;
  logic       done;
  logic [2:0] codons_played;

  codon_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .codon_mask    (codon_mask),
    .done_reader   (done_reader),
    .codon1        (codon1),
    .codon2        (codon2),
    .codon3        (codon3),
    .codon4        (codon4),
    .codon5        (codon5),
    .end_of_codon  (end_of_codon),
    .codon_index   (codon_index),
    .nibble_out    (nibble_out),
    .nibble_valid  (nibble_valid),
    .nibble_ready  (nibble_ready),
    .codon_id      (codon_id),
    .last_nibble   (last_nibble),
    .busy          (busy),
    .done          (done),
    .codons_played (codons_played)
  );

  always #5 clock = ~clock;

  // Reader model: codon contents as plain arrays, padded with 4'hF.
  logic [3:0] mem [5][6];
  logic [3:0] rd_nib [5];

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      rd_nib[k]       = 4'hF;
      end_of_codon[k] = 1'b0;
      if (codon_index < 3'd6) rd_nib[k] = mem[k][codon_index];
      if (codon_index < 3'd5) end_of_codon[k] = (mem[k][codon_index + 3'd1] == 4'hF);
    end
  end
  assign codon1 = rd_nib[0];
  assign codon2 = rd_nib[1];
  assign codon3 = rd_nib[2];
  assign codon4 = rd_nib[3];
  assign codon5 = rd_nib[4];

  // Expected stream entry: {codon_id, codon_index, nibble, last}
  logic [10:0] exp_q [$];
  int          exp_played;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          ready_rand = 1'b0;
  bit          stall_prev = 1'b0;
  logic [3:0]  prev_nib;
  logic [2:0]  prev_idx, prev_id;

  // Behavioural model: walk enabled codons, emit nibbles until F or slot 6.
  task automatic build_expected(input logic [4:0] mask);
    exp_q.delete();
    exp_played = 0;
    for (int k = 0; k < 5; k++) begin
      if (mask[k] && mem[k][0] != 4'hF) begin
        for (int j = 0; j < 6; j++) begin
          bit last;
          if (mem[k][j] == 4'hF) break;
          if (j == 5) last = 1'b1;
          else        last = (mem[k][j+1] == 4'hF);
          exp_q.push_back({3'(k), 3'(j), mem[k][j], last});
        end
        exp_played++;
      end
    end
  endtask

  task automatic load_plan_data();
    logic [3:0] rows [5][6];
    rows[0] = '{4'hA, 4'hB, 4'hC, 4'hF, 4'hF, 4'hF};
    rows[1] = '{4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    rows[2] = '{4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    rows[3] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'hF, 4'hF};
    rows[4] = '{4'h9, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 6; j++) mem[k][j] = rows[k][j];
  endtask

  task automatic load_random_data();
    for (int k = 0; k < 5; k++) begin
      int len = $urandom_range(0, 6);
      for (int j = 0; j < 6; j++)
        mem[k][j] = (j < len) ? 4'($urandom_range(0, 14)) : 4'hF;
    end
  endtask

  // Ready generation and scoreboard, both on the falling edge.
  always @(negedge clock) begin
    logic        rdy;
    logic [10:0] e;
    rdy = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    nibble_ready = rdy;
    if (mon_en && reset_n) begin
      if (stall_prev) begin
        n_cmp++;
        if (!nibble_valid || nibble_out !== prev_nib || codon_index !== prev_idx ||
            codon_id !== prev_id) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b nib=%h idx=%0d id=%0d, need valid=1 nib=%h idx=%0d id=%0d",
                   nibble_valid, nibble_out, codon_index, codon_id, prev_nib, prev_idx, prev_id);
        end
      end
      if (nibble_valid && rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_nibble: got id=%0d idx=%0d nib=%h, need no transfer",
                   codon_id, codon_index, nibble_out);
        end else begin
          e = exp_q.pop_front();
          if ({codon_id, codon_index, nibble_out, last_nibble} !== e) begin
            n_err++;
            $display("FAIL stream_beat: got id=%0d idx=%0d nib=%h last=%0b, need id=%0d idx=%0d nib=%h last=%0b",
                     codon_id, codon_index, nibble_out, last_nibble, e[10:8], e[7:5], e[4:1], e[0]);
          end
        end
      end
      stall_prev = nibble_valid && !rdy;
      prev_nib   = nibble_out;
      prev_idx   = codon_index;
      prev_id    = codon_id;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic pulse_start(input logic [4:0] mask);
    @(negedge clock);
    codon_mask = mask;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({done, busy, nibble_valid, last_nibble, nibble_out} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_status: got done=%0b busy=%0b valid=%0b last=%0b nib=%h, need all 0",
               done, busy, nibble_valid, last_nibble, nibble_out);
    end
    n_cmp++;
    if ({codon_index, codon_id, codons_played} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_counters: got idx=%0d id=%0d played=%0d, need 0 0 0",
               codon_index, codon_id, codons_played);
    end
  endtask

  task automatic test_full_mask();
    bit ok;
    load_plan_data();
    build_expected(5'b11111);
    mon_en = 1'b1;
    pulse_start(5'b11111);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL full_accept: got done=%0b busy=%0b, need 0 1", done, busy);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd5 || busy !== 1'b0 || codon_index !== 3'd0) begin
      n_err++;
      $display("FAIL full_end: got done=%0b left=%0d played=%0d busy=%0b idx=%0d, need 1 0 5 0 0",
               ok, exp_q.size(), codons_played, busy, codon_index);
    end
  endtask

  task automatic test_sparse_mask();
    bit ok;
    load_plan_data();
    build_expected(5'b10101);
    pulse_start(5'b10101);
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd3) begin
      n_err++;
      $display("FAIL sparse_end: got done=%0b left=%0d played=%0d, need 1 0 3", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_empty_codon();
    bit ok;
    load_plan_data();
    mem[2][0] = 4'hF;
    build_expected(5'b11111);
    pulse_start(5'b11111);
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd4) begin
      n_err++;
      $display("FAIL empty_end: got done=%0b left=%0d played=%0d, need 1 0 4", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_full_length();
    bit ok;
    load_plan_data();
    for (int j = 0; j < 6; j++) mem[0][j] = 4'(j + 1);
    build_expected(5'b00011);
    pulse_start(5'b00011);
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd2) begin
      n_err++;
      $display("FAIL fulllen_end: got done=%0b left=%0d played=%0d, need 1 0 2", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    load_plan_data();
    build_expected(5'b11111);
    ready_rand = 1'b1;
    pulse_start(5'b11111);
    wait_done(ok);
    ready_rand = 1'b0;
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd5) begin
      n_err++;
      $display("FAIL toggle_end: got done=%0b left=%0d played=%0d, need 1 0 5", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_wait_reader_busy_start();
    bit ok;
    load_plan_data();
    build_expected(5'b11111);
    done_reader = 1'b0;
    pulse_start(5'b11111);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1 || nibble_valid !== 1'b0 || codon_index !== 3'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL wait_reader: got busy=%0b valid=%0b idx=%0d done=%0b, need 1 0 0 0",
               busy, nibble_valid, codon_index, done);
    end
    done_reader = 1'b1;
    repeat (5) @(negedge clock);
    pulse_start(5'b00000);   // must be ignored while busy
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd5) begin
      n_err++;
      $display("FAIL busy_start: got done=%0b left=%0d played=%0d, need 1 0 5", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_zero_mask();
    bit ok;
    load_plan_data();
    build_expected(5'b00000);
    pulse_start(5'b00000);
    wait_done(ok);
    n_cmp++;
    if (!ok || codons_played !== 3'd0) begin
      n_err++;
      $display("FAIL zero_mask: got done=%0b played=%0d, need 1 0", ok, codons_played);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    bit hit;
    load_plan_data();
    build_expected(5'b11111);
    pulse_start(5'b11111);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (nibble_valid && codon_id == 3'd1 && codon_index == 3'd1) begin hit = 1'b1; break; end
    end
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (!hit || {busy, done, nibble_valid, last_nibble, nibble_out, codon_index, codon_id, codons_played} !== 17'd0) begin
      n_err++;
      $display("FAIL mid_reset: reached=%0b got busy=%0b done=%0b valid=%0b idx=%0d id=%0d played=%0d, need reached=1 and all 0",
               hit, busy, done, nibble_valid, codon_index, codon_id, codons_played);
    end
    @(negedge clock);
    reset_n = 1'b1;
    build_expected(5'b11111);
    mon_en = 1'b1;
    pulse_start(5'b11111);
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || codons_played !== 3'd5) begin
      n_err++;
      $display("FAIL replay_end: got done=%0b left=%0d played=%0d, need 1 0 5", ok, exp_q.size(), codons_played);
    end
  endtask

  task automatic test_random();
    bit         ok;
    logic [4:0] mask;
    for (int it = 0; it < 20; it++) begin
      load_random_data();
      mask = 5'($urandom_range(0, 31));
      build_expected(mask);
      ready_rand = 1'($urandom_range(0, 1));
      pulse_start(mask);
      wait_done(ok);
      n_cmp++;
      if (!ok || exp_q.size() != 0 || codons_played !== 3'(exp_played)) begin
        n_err++;
        $display("FAIL random_run%0d: got done=%0b left=%0d played=%0d, need 1 0 %0d",
                 it, ok, exp_q.size(), codons_played, exp_played);
      end
    end
    ready_rand = 1'b0;
  endtask

  initial begin
    load_plan_data();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_codon();
    test_full_length();
    test_ready_toggle();
    test_wait_reader_busy_start();
    test_zero_mask();
    test_reset_mid_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
